param_mode_counter: RTL

Parametrised successor to the team's fixed 4-bit free-running counter. Adds configurable width, programmable terminal limit, up/down direction, parallel load, count enable, and four run modes: wrap, saturate, one-shot and ping-pong. It also produces registered terminal-count and done status. It serves as the general-purpose event/timer counter for the datapath and test fixtures.

---
 rtl/param_mode_counter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/param_mode_counter.sv
// Parametrised event/timer counter: wrap, saturate, one-shot and ping-pong modes with load and limit.
// Latency: one cycle from an enabled step or load to count/tc/done/pp_dir; no backpressure, all outputs registered.
module param_mode_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             pp_dir
);

    typedef enum logic [1:0] {
        M_WRAP     = 2'b00,
        M_SAT      = 2'b01,
        M_ONESHOT  = 2'b10,
        M_PINGPONG = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    mode_t            cur_mode;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;
    logic             done_n;
    logic             pp_dir_n;
    logic             up;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] ld_clamped;
    logic             frozen;

    assign cur_mode = mode_t'(mode);

    always_comb begin
        ld_clamped = (load_val > limit) ? limit : load_val;
        up         = (cur_mode == M_PINGPONG) ? pp_dir : dir;
        term       = up ? limit : '0;
        step       = up ? (count + ONE) : (count - ONE);
        frozen     = done && (cur_mode == M_ONESHOT);

        count_n  = count;
        tc_n     = 1'b0;
        done_n   = done && (cur_mode == M_ONESHOT);
        pp_dir_n = pp_dir;

        if (load) begin
            count_n  = ld_clamped;
            done_n   = 1'b0;
            pp_dir_n = (ld_clamped != limit);
        end else if (en && !frozen) begin
            if (count > limit) begin
                // Limit was lowered below the current count: re-enter the range without a terminal event.
                count_n = up ? '0 : limit;
            end else begin
                case (cur_mode)
                    M_WRAP: begin
                        if (count == term) begin
                            count_n = up ? '0 : limit;
                            tc_n    = 1'b1;
                        end else begin
                            count_n = step;
                        end
                    end
                    M_SAT, M_ONESHOT: begin
                        if (count != term) begin
                            count_n = step;
                            if (step == term) begin
                                tc_n   = 1'b1;
                                done_n = (cur_mode == M_ONESHOT);
                            end
                        end else if (cur_mode == M_ONESHOT) begin
                            // Already parked on the terminal (e.g. limit=0): finish without a pulse.
                            done_n = 1'b1;
                        end
                    end
                    M_PINGPONG: begin
                        if (limit != '0) begin
                            if (pp_dir ? (count == limit) : (count == '0)) begin
                                count_n = pp_dir ? (count - ONE) : (count + ONE);
                            end else begin
                                count_n = step;
                            end
                            if (count_n == limit) begin
                                pp_dir_n = 1'b0;
                            end else if (count_n == '0) begin
                                pp_dir_n = 1'b1;
                                tc_n     = 1'b1;
                            end else begin
                                pp_dir_n = (count_n > count);
                            end
                        end
                    end
                    default: count_n = count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= RST_COUNT;
            tc     <= 1'b0;
            done   <= 1'b0;
            pp_dir <= 1'b1;
        end else begin
            count  <= count_n;
            tc     <= tc_n;
            done   <= done_n;
            pp_dir <= pp_dir_n;
        end
    end

endmodule
